fir_tap_sequencer: RTL and testbench
====================================

# fir_tap_sequencer

Feeds the serial MAC datapath of the FIR filter. It accepts one input sample per filter period over a valid/ready handshake and stores it in a circular delay-line buffer. It then streams the NUMBER_OF_TAPS (sample, coefficient) pairs one per enabled cycle, together with the accumulator-restart marker and the MAC clock-enable. Its outputs connect directly to the compute block's `delay_filter_in`, `coeff`, `phase_min` and `clk_enable` inputs.

## Interface
- FILTER_IN_BITS, 16, sample width (signed)
- COEFF_BITS, 16, coefficient width (signed)
- NUMBER_OF_TAPS, 64, filter length; legal range 2..1024, need not be a power of two
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- clk_enable  in  1  global stall; low = all state holds
- in_valid  in  1  `filter_in` holds a new sample
- in_ready  out  1  sequencer can accept a sample this cycle (combinational)
- filter_in  in  FILTER_IN_BITS  new sample x[n]
- coeffs  in  NUMBER_OF_TAPS*COEFF_BITS  packed coefficients; c[i] = coeffs[i*COEFF_BITS +: COEFF_BITS]; static during operation
- delay_filter_in  out  FILTER_IN_BITS  tap sample x[n-i] (registered)
- coeff  out  COEFF_BITS  c[i] matching `delay_filter_in` (registered)
- phase_min  out  1  high only with tap 0 (registered)
- mac_enable  out  1  drives compute `clk_enable`; high on every tap cycle (registered)
- busy  out  1  state == RUN

## Operation
- States: IDLE, RUN. Reset -> IDLE.
- Accept = clk_enable & in_valid & in_ready.
- in_ready = clk_enable & (IDLE | (RUN & tap_cnt == NUMBER_OF_TAPS-1)). Back-to-back samples are allowed, giving a throughput of 1 sample per NUMBER_OF_TAPS enabled cycles.
- On accept:
  - write filter_in to buf[wr_ptr]
  - newest <= wr_ptr
  - wr_ptr <= (wr_ptr+1) mod NUMBER_OF_TAPS
  - tap_cnt <= 0
  - state <= RUN
- RUN, each enabled cycle, output registers load tap i = tap_cnt:
  - delay_filter_in <= buf[(newest - i) mod NUMBER_OF_TAPS], with explicit modular wrap and no power-of-two shortcut
  - coeff <= c[i]
  - phase_min <= (i == 0)
  - mac_enable <= 1
- After tap NUMBER_OF_TAPS-1 with no accept: state <= IDLE. Output registers then load zeros with phase_min = 0 and mac_enable = 0.
- IDLE: outputs zero, mac_enable = 0, phase_min = 0.
- clk_enable low: all state, buffer, counters and output registers hold, except mac_enable, which is forced to 0 on the next edge.
- in_valid while in_ready is low: ignored, nothing is written.
- Buffer entries reset to 0, so the first NUMBER_OF_TAPS-1 periods see zero history.
- Result of period k is latched by compute at phase_min of period k+1. No flush mode.

## Timing
- Reset (rst_n low at an edge) gives the following output values, all held while rst_n stays low:
  - delay_filter_in = 0, coeff = 0
  - phase_min = 0, mac_enable = 0, busy = 0
  - in_ready = 0
  - buffer, wr_ptr and tap_cnt = 0
- in_ready becomes high in the first cycle after release, given clk_enable is high.
- Accept at edge E: tap i appears on the outputs after edge E+1+i (counting enabled edges), for i = 0..NUMBER_OF_TAPS-1.
- phase_min is high for exactly the one cycle that carries tap 0.
- Back-to-back: accept at the edge ending tap N-1, so the next period's tap 0 follows immediately with no bubble.
- Reset mid-RUN: abandons the period next edge, outputs return to reset values, and buffer history is cleared.

## Structure
- Package `fir_pkg`:
  - state enum `seq_state_t` {IDLE, RUN}
  - function `tap_idx_bits(n)` = max(1, $clog2(n))
  - wrap-subtract helper
- Sub-module `fir_sample_buffer`: NUMBER_OF_TAPS x FILTER_IN_BITS flop array, one write port, one combinational read port (index input), synchronous active-low clear.
- Top level holds the FSM, tap counter, pointers, coefficient mux and output registers.

## Test plan
- Impulse: after reset, coeffs c[i] = i+1, send 0x0100 -> tap 0 = 0x0100 with coeff 1 and phase_min = 1; taps 1..63 = 0 with coeff i+1; mac_enable high exactly 64 cycles.
- Back-to-back: send 0x0100, then 0x0200 at the first in_ready -> second period tap 0 = 0x0200, tap 1 = 0x0100, rest 0; no idle cycle between periods.
- Wrap-around: NUMBER_OF_TAPS = 5, send 1..7 -> period for sample 7 streams 7,6,5,4,3.
- Stall: drop clk_enable for 3 cycles at tap 10 -> outputs frozen at tap 10, mac_enable low 3 cycles, then taps 11..63 resume with no tap skipped or repeated.
- Handshake: in_valid high during RUN taps 0..62 -> no write; accepted only at tap 63.
- Reset mid-RUN at tap 20 -> all outputs 0 next cycle; the next sample streams with zero history.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR tap sequencer.
package fir_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  // Index width for a table of n entries, never less than one bit.
  function automatic int unsigned tap_idx_bits(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // (a - b) mod n for operands already in 0..n-1; no power-of-two assumption.
  function automatic int unsigned wrap_sub(input int unsigned a, input int unsigned b,
                                           input int unsigned n);
    return (a >= b) ? (a - b) : (a + n - b);
  endfunction

endpackage

// File: rtl/fir_sample_buffer.sv
// Circular delay-line storage: one write port, one combinational read port.
module fir_sample_buffer
  import fir_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IW    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_idx] = wr_data;
  end

  // Clearing on reset guarantees zero history for the first periods.
  always_ff @(posedge clk) begin
    if (!rst_n) mem_q <= '{default: '0};
    else        mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/fir_tap_sequencer.sv
// Accepts one sample per filter period and streams (sample, coeff) tap pairs
// to the serial MAC, with restart marker and MAC clock-enable.
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int unsigned FILTER_IN_BITS = 16,
  parameter int unsigned COEFF_BITS     = 16,
  parameter int unsigned NUMBER_OF_TAPS = 64
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clk_enable,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [FILTER_IN_BITS-1:0]            filter_in,
  input  logic [NUMBER_OF_TAPS*COEFF_BITS-1:0] coeffs,
  output logic [FILTER_IN_BITS-1:0]            delay_filter_in,
  output logic [COEFF_BITS-1:0]                coeff,
  output logic                                 phase_min,
  output logic                                 mac_enable,
  output logic                                 busy
);

  localparam int unsigned   IW   = tap_idx_bits(NUMBER_OF_TAPS);
  localparam logic [IW-1:0] LAST = IW'(NUMBER_OF_TAPS - 1);

  seq_state_t              state_q, state_d;
  logic [IW-1:0]           tap_cnt_q, tap_cnt_d;
  logic [IW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [IW-1:0]           newest_q, newest_d;
  logic [FILTER_IN_BITS-1:0] dfi_q, dfi_d;
  logic [COEFF_BITS-1:0]   coeff_q, coeff_d;
  logic                    phase_min_q, phase_min_d;
  logic                    mac_enable_q, mac_enable_d;

  logic                    accept;
  logic [IW-1:0]           rd_idx;
  logic [FILTER_IN_BITS-1:0] rd_data;
  logic [COEFF_BITS-1:0]   coeff_tbl [NUMBER_OF_TAPS];

  for (genvar g = 0; g < NUMBER_OF_TAPS; g++) begin : g_coeff
    assign coeff_tbl[g] = coeffs[g*COEFF_BITS +: COEFF_BITS];
  end

  // Ready in IDLE, or on the last tap so the next period follows with no bubble.
  assign in_ready = rst_n & clk_enable &
                    ((state_q == IDLE) | ((state_q == RUN) & (tap_cnt_q == LAST)));
  assign accept   = in_valid & in_ready;

  assign rd_idx = IW'(wrap_sub(32'(newest_q), 32'(tap_cnt_q), NUMBER_OF_TAPS));

  fir_sample_buffer #(
    .DEPTH (NUMBER_OF_TAPS),
    .WIDTH (FILTER_IN_BITS),
    .IW    (IW)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept),
    .wr_idx  (wr_ptr_q),
    .wr_data (filter_in),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d      = state_q;
    tap_cnt_d    = tap_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    newest_d     = newest_q;
    dfi_d        = dfi_q;
    coeff_d      = coeff_q;
    phase_min_d  = phase_min_q;
    mac_enable_d = 1'b0;

    if (clk_enable) begin
      case (state_q)
        IDLE: begin
          dfi_d       = '0;
          coeff_d     = '0;
          phase_min_d = 1'b0;
        end
        RUN: begin
          dfi_d        = rd_data;
          coeff_d      = coeff_tbl[tap_cnt_q];
          phase_min_d  = (tap_cnt_q == '0);
          mac_enable_d = 1'b1;
          if (tap_cnt_q == LAST) begin
            state_d   = IDLE;
            tap_cnt_d = '0;
          end else begin
            tap_cnt_d = tap_cnt_q + IW'(1);
          end
        end
        default: state_d = IDLE;
      endcase

      // A new sample restarts the period; the write lands on the same edge.
      if (accept) begin
        newest_d  = wr_ptr_q;
        wr_ptr_d  = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + IW'(1);
        tap_cnt_d = '0;
        state_d   = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tap_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      newest_q     <= '0;
      dfi_q        <= '0;
      coeff_q      <= '0;
      phase_min_q  <= 1'b0;
      mac_enable_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tap_cnt_q    <= tap_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      newest_q     <= newest_d;
      dfi_q        <= dfi_d;
      coeff_q      <= coeff_d;
      phase_min_q  <= phase_min_d;
      mac_enable_q <= mac_enable_d;
    end
  end

  assign delay_filter_in = dfi_q;
  assign coeff           = coeff_q;
  assign phase_min       = phase_min_q;
  assign mac_enable      = mac_enable_q;
  assign busy            = (state_q == RUN);

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: a 64-tap and a 5-tap instance checked every
// cycle against a history-queue reference model, plus directed scenarios.
module tb_fir_tap_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, clk_enable;
  logic        v64, v5;
  logic [15:0] d64, d5;
  logic [15:0] c64 [64];
  logic [15:0] c5  [64];
  logic [64*16-1:0] coeffs64;
  logic [5*16-1:0]  coeffs5;

  always_comb begin
    for (int i = 0; i < 64; i++) coeffs64[i*16 +: 16] = c64[i];
    for (int i = 0; i < 5; i++)  coeffs5[i*16 +: 16]  = c5[i];
  end

  logic        rdy64, pm64, mac64, busy64;
  logic [15:0] dfi64, cf64;
  logic        rdy5, pm5, mac5, busy5;
  logic [15:0] dfi5, cf5;

  fir_tap_sequencer #(.FILTER_IN_BITS(16), .COEFF_BITS(16), .NUMBER_OF_TAPS(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable), .in_valid(v64), .in_ready(rdy64),
    .filter_in(d64), .coeffs(coeffs64), .delay_filter_in(dfi64), .coeff(cf64),
    .phase_min(pm64), .mac_enable(mac64), .busy(busy64));

  fir_tap_sequencer #(.FILTER_IN_BITS(16), .COEFF_BITS(16), .NUMBER_OF_TAPS(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable), .in_valid(v5), .in_ready(rdy5),
    .filter_in(d5), .coeffs(coeffs5), .delay_filter_in(dfi5), .coeff(cf5),
    .phase_min(pm5), .mac_enable(mac5), .busy(busy5));

  // Model: hist[k] is x[n-k]; remaining = taps of the current period still to emit.
  typedef struct {
    logic [15:0] hist [64];
    int          remaining;
    int          n;
    logic [15:0] dfi;
    logic [15:0] coeff;
    logic        phase;
    logic        mac;
  } model_t;

  model_t m64, m5;
  int n_tests = 0;
  int n_fail  = 0;

  function automatic void model_step(inout model_t m, input logic rst_l, input logic en,
                                     input logic valid, input logic [15:0] din,
                                     input logic [15:0] cf [64]);
    int   t;
    logic acc;
    if (!rst_l) begin
      for (int i = 0; i < 64; i++) m.hist[i] = '0;
      m.remaining = 0;
      m.dfi = '0; m.coeff = '0; m.phase = 1'b0; m.mac = 1'b0;
    end else if (en) begin
      acc = valid && (m.remaining <= 1);
      if (m.remaining > 0) begin
        t = m.n - m.remaining;
        m.dfi = m.hist[t]; m.coeff = cf[t]; m.phase = (t == 0); m.mac = 1'b1;
        m.remaining--;
      end else begin
        m.dfi = '0; m.coeff = '0; m.phase = 1'b0; m.mac = 1'b0;
      end
      if (acc) begin
        for (int i = m.n - 1; i > 0; i--) m.hist[i] = m.hist[i-1];
        m.hist[0]   = din;
        m.remaining = m.n;
      end
    end else begin
      m.mac = 1'b0;
    end
  endfunction

  function automatic logic model_ready(input model_t m, input logic rst_l, input logic en);
    return rst_l && en && (m.remaining <= 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(m64, rst_n, clk_enable, v64, d64, c64);
    model_step(m5,  rst_n, clk_enable, v5,  d5,  c5);
    #1;
    chk("dfi64",   32'(dfi64),  32'(m64.dfi));
    chk("coeff64", 32'(cf64),   32'(m64.coeff));
    chk("phase64", 32'(pm64),   32'(m64.phase));
    chk("mac64",   32'(mac64),  32'(m64.mac));
    chk("busy64",  32'(busy64), 32'(m64.remaining > 0));
    chk("ready64", 32'(rdy64),  32'(model_ready(m64, rst_n, clk_enable)));
    chk("dfi5",    32'(dfi5),   32'(m5.dfi));
    chk("coeff5",  32'(cf5),    32'(m5.coeff));
    chk("phase5",  32'(pm5),    32'(m5.phase));
    chk("mac5",    32'(mac5),   32'(m5.mac));
    chk("busy5",   32'(busy5),  32'(m5.remaining > 0));
    chk("ready5",  32'(rdy5),   32'(model_ready(m5, rst_n, clk_enable)));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; v64 = 1'b0; v5 = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic send64(input logic [15:0] x);
    logic acc = 1'b0;
    v64 = 1'b1; d64 = x;
    for (int k = 0; k < 200 && !acc; k++) begin
      acc = model_ready(m64, rst_n, clk_enable);
      tick();
    end
    chk("send64_accepted", 32'(acc), 32'd1);
    v64 = 1'b0;
  endtask

  task automatic send5(input logic [15:0] x);
    logic acc = 1'b0;
    v5 = 1'b1; d5 = x;
    for (int k = 0; k < 50 && !acc; k++) begin
      acc = model_ready(m5, rst_n, clk_enable);
      tick();
    end
    chk("send5_accepted", 32'(acc), 32'd1);
    v5 = 1'b0;
  endtask

  typedef struct {
    logic [15:0] din;
    int          tap;
    logic [15:0] exp_dfi;
    logic [15:0] exp_coeff;
    logic        exp_phase;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        imp_tbl [6];
    vec_t        wrap_tbl [5];
    int          mac_cnt;
    int          rdy_cnt;
    logic [15:0] frozen;

    imp_tbl[0] = '{16'h0100, 0,  16'h0100, 16'd1,  1'b1};
    imp_tbl[1] = '{16'h0100, 1,  16'h0000, 16'd2,  1'b0};
    imp_tbl[2] = '{16'h0100, 2,  16'h0000, 16'd3,  1'b0};
    imp_tbl[3] = '{16'h0100, 31, 16'h0000, 16'd32, 1'b0};
    imp_tbl[4] = '{16'h0100, 62, 16'h0000, 16'd63, 1'b0};
    imp_tbl[5] = '{16'h0100, 63, 16'h0000, 16'd64, 1'b0};
    for (int k = 0; k < 5; k++)
      wrap_tbl[k] = '{16'(7 - k), k, 16'(7 - k), 16'(k + 1), (k == 0)};

    m64.n = 64; m5.n = 5;
    m64.remaining = 0; m5.remaining = 0;
    rst_n = 1'b0; clk_enable = 1'b1;
    v64 = 1'b0; v5 = 1'b0; d64 = '0; d5 = '0;
    for (int i = 0; i < 64; i++) begin
      c64[i] = 16'(i + 1);
      c5[i]  = (i < 5) ? 16'(i + 1) : 16'h0;
    end

    // Reset values and first ready after release.
    do_reset();
    chk("rst_dfi",  32'(dfi64),  32'd0);
    chk("rst_mac",  32'(mac64),  32'd0);
    chk("rst_busy", 32'(busy64), 32'd0);
    #1;
    chk("ready_after_release", 32'(rdy64), 32'd1);

    // Impulse, spot-checked against the vector table.
    send64(imp_tbl[0].din);
    mac_cnt = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (mac64) mac_cnt++;
      for (int k = 0; k < 6; k++) begin
        if (imp_tbl[k].tap == i) begin
          chk("imp_dfi",   32'(dfi64), 32'(imp_tbl[k].exp_dfi));
          chk("imp_coeff", 32'(cf64),  32'(imp_tbl[k].exp_coeff));
          chk("imp_phase", 32'(pm64),  32'(imp_tbl[k].exp_phase));
        end
      end
    end
    chk("imp_mac_cycles", 32'(mac_cnt), 32'd64);

    // Back-to-back periods.
    do_reset();
    send64(16'h0100);
    send64(16'h0200);
    tick();
    chk("b2b_tap0", 32'(dfi64), 32'h0200);
    chk("b2b_phase", 32'(pm64), 32'd1);
    chk("b2b_mac", 32'(mac64), 32'd1);
    tick();
    chk("b2b_tap1", 32'(dfi64), 32'h0100);
    tick();
    chk("b2b_tap2", 32'(dfi64), 32'h0000);
    for (int i = 0; i < 64; i++) tick();

    // Wrap-around on the 5-tap instance.
    do_reset();
    for (int s = 1; s <= 7; s++) send5(16'(s));
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("wrap_dfi",   32'(dfi5), 32'(wrap_tbl[k].exp_dfi));
      chk("wrap_coeff", 32'(cf5),  32'(wrap_tbl[k].exp_coeff));
      chk("wrap_phase", 32'(pm5),  32'(wrap_tbl[k].exp_phase));
    end
    for (int i = 0; i < 4; i++) tick();

    // Stall at tap 10.
    do_reset();
    send64(16'h0100);
    for (int i = 0; i <= 10; i++) tick();
    chk("stall_tap10", 32'(cf64), 32'd11);
    frozen = dfi64;
    clk_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_coeff", 32'(cf64), 32'd11);
      chk("stall_dfi", 32'(dfi64), 32'(frozen));
      chk("stall_mac", 32'(mac64), 32'd0);
    end
    clk_enable = 1'b1;
    for (int i = 11; i < 64; i++) begin
      tick();
      chk("stall_resume", 32'(cf64), 32'(i + 1));
    end
    tick();
    chk("stall_done_mac", 32'(mac64), 32'd0);

    // in_valid held through RUN: only the last tap accepts.
    do_reset();
    send64(16'h0100);
    v64 = 1'b1; d64 = 16'hBEEF;
    rdy_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      if (rdy64) rdy_cnt++;
      tick();
    end
    v64 = 1'b0;
    chk("hs_ready_cycles", 32'(rdy_cnt), 32'd1);
    tick();
    chk("hs_tap0", 32'(dfi64), 32'hBEEF);
    tick();
    chk("hs_tap1", 32'(dfi64), 32'h0100);
    for (int i = 0; i < 64; i++) tick();

    // Reset mid-RUN clears outputs and history.
    do_reset();
    send64(16'h0100);
    send64(16'h0200);
    for (int i = 0; i < 20; i++) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_dfi",  32'(dfi64),  32'd0);
    chk("midrst_mac",  32'(mac64),  32'd0);
    chk("midrst_busy", 32'(busy64), 32'd0);
    rst_n = 1'b1;
    send64(16'h0300);
    tick();
    chk("midrst_tap0", 32'(dfi64), 32'h0300);
    tick();
    chk("midrst_tap1", 32'(dfi64), 32'h0000);

    // Randomized traffic with random coefficients.
    rst_n = 1'b0;
    for (int i = 0; i < 64; i++) begin
      c64[i] = 16'($urandom);
      c5[i]  = (i < 5) ? 16'($urandom) : 16'h0;
    end
    tick();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      clk_enable = ($urandom_range(0, 9) != 0);
      v64 = 1'($urandom_range(0, 1));
      v5  = 1'($urandom_range(0, 1));
      d64 = 16'($urandom);
      d5  = 16'($urandom);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
